bnn_sequencer: RTL and testbench

//  Controller in front of the 8-8-4 BNN datapath. Feeds inference samples through its 2-register pipeline with valid/ready flow control.

---
 rtl/bnn_pkg.sv | 14 +
 rtl/bnn_result_fifo.sv | 45 ++++
 rtl/bnn_sequencer.sv | 127 ++++++++++++
 tb/tb_bnn_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared constants and FSM state type for the BNN sequencer slice.
package bnn_pkg;
   localparam int NUM_NEURONS = 12;
   localparam int NIB_W       = 4;
   localparam int OUT_W       = 4;

   typedef enum logic [2:0] {
      RUN   = 3'd0,
      DRAIN = 3'd1,
      CLR   = 3'd2,
      LOAD  = 3'd3,
      FIN   = 3'd4
   } bnn_state_e;
endpackage

// File: rtl/bnn_result_fifo.sv
// Result FIFO: registered storage, head visible combinationally on dout.
// Latency: push visible one cycle later; push while full only accepted alongside a pop.
// Backpressure: head holds until pop; producer is kept in bounds by upstream credits.
module bnn_result_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((int'(count) < DEPTH) || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (!do_push && do_pop) count <= count - CW'(1);
      end
   end
endmodule

// File: rtl/bnn_sequencer.sv
// Sequencer for the 8-8-4 BNN datapath: credit-gated inference, result FIFO, weight reload serializer.
// Latency: 3 cycles accept-to-FIFO; reload issues 2 nibbles per weight byte. Optional BNN_SEQ_PERF_EN counters.
// Backpressure: in_ready drops when FIFO+in-flight reach RES_DEPTH or a reload is pending/active.
module bnn_sequencer
   import bnn_pkg::*;
#(
   parameter int NUM_NEURONS = bnn_pkg::NUM_NEURONS,
   parameter int RES_DEPTH   = 4,
   parameter int PIPE_LAT    = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   input  logic             wl_start,
   input  logic             wl_valid,
   output logic             wl_ready,
   input  logic [7:0]       wl_data,
   output logic             load_done,
   output logic             busy,
   output logic             bnn_rst,
   output logic [7:0]       bnn_in,
   output logic             bnn_load_en,
   output logic [NIB_W-1:0] bnn_nibble,
   input  logic [OUT_W-1:0] bnn_out,
   output logic [15:0]      perf_infer,
   output logic [15:0]      perf_stall
);
   localparam int CNT_W  = $clog2(NUM_NEURONS + 1);
   localparam int FIFO_CW = $clog2(RES_DEPTH + 1);

   bnn_state_e         state;
   logic [PIPE_LAT-1:0] pv;
   logic [CNT_W-1:0]   cnt;
   logic               hi_pend;
   logic [NIB_W-1:0]   hi_nib;
   logic [FIFO_CW-1:0] fifo_cnt;
   logic               credit_ok;
   logic               accept;
   logic               pop;
   logic               all_issued;

   // Credits count results still in the pipe so a full FIFO can never be overrun.
   assign credit_ok  = (int'(fifo_cnt) + $countones(pv)) < RES_DEPTH;
   assign in_ready   = !reset && (state == RUN) && !wl_start && credit_ok;
   assign accept     = in_valid && in_ready;
   assign out_valid  = (fifo_cnt != '0);
   assign pop        = out_valid && out_ready;
   assign all_issued = (cnt == CNT_W'(NUM_NEURONS));
   assign wl_ready   = !reset && (state == LOAD) && !hi_pend && !all_issued;
   assign load_done  = !reset && (state == FIN);
   assign busy       = !reset && (state != RUN);
   assign bnn_rst    = reset || (state == CLR);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= RUN;
         pv          <= '0;
         cnt         <= '0;
         hi_pend     <= 1'b0;
         hi_nib      <= '0;
         bnn_in      <= '0;
         bnn_load_en <= 1'b0;
         bnn_nibble  <= '0;
      end else begin
         pv          <= {pv[PIPE_LAT-2:0], accept};
         bnn_load_en <= 1'b0;
         if (accept) bnn_in <= in_data;
         case (state)
            RUN:   if (wl_start) state <= DRAIN;
            DRAIN: if (pv == '0) state <= CLR;
            CLR: begin
               cnt     <= '0;
               hi_pend <= 1'b0;
               state   <= LOAD;
            end
            LOAD: begin
               // The last high nibble goes out one cycle before FIN so load_done never overlaps load_en.
               if (all_issued) begin
                  state <= FIN;
               end else if (hi_pend) begin
                  bnn_load_en <= 1'b1;
                  bnn_nibble  <= hi_nib;
                  hi_pend     <= 1'b0;
                  cnt         <= cnt + CNT_W'(1);
               end else if (wl_valid) begin
                  bnn_load_en <= 1'b1;
                  bnn_nibble  <= wl_data[3:0];
                  hi_nib      <= wl_data[7:4];
                  hi_pend     <= 1'b1;
               end
            end
            FIN:     state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

   bnn_result_fifo #(.WIDTH(OUT_W), .DEPTH(RES_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (pv[PIPE_LAT-1]),
      .din   (bnn_out),
      .pop   (pop),
      .dout  (out_data),
      .count (fifo_cnt)
   );

`ifdef BNN_SEQ_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_infer <= '0;
         perf_stall <= '0;
      end else begin
         if (pop && (perf_infer != 16'hFFFF)) perf_infer <= perf_infer + 16'd1;
         if (in_valid && !in_ready && (perf_stall != 16'hFFFF)) perf_stall <= perf_stall + 16'd1;
      end
   end
`else
   assign perf_infer = '0;
   assign perf_stall = '0;
`endif
endmodule

// File: tb/tb_bnn_sequencer.sv
// Bench for bnn_sequencer with a behavioural 8-8-4 XNOR/popcount datapath and a functional result model.
module tb_bnn_sequencer;
   localparam int NN = 12;

   logic       clk = 1'b0;
   logic       reset, in_valid, out_ready, wl_start, wl_valid;
   logic [7:0] in_data, wl_data;
   logic       in_ready, out_valid, wl_ready, load_done, busy, bnn_rst, bnn_load_en;
   logic [3:0] out_data, bnn_nibble, bnn_out;
   logic [7:0] bnn_in;
   logic [15:0] perf_infer, perf_stall;

   always #5 clk = ~clk;

   bnn_sequencer dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .wl_start(wl_start), .wl_valid(wl_valid), .wl_ready(wl_ready), .wl_data(wl_data),
      .load_done(load_done), .busy(busy), .bnn_rst(bnn_rst), .bnn_in(bnn_in),
      .bnn_load_en(bnn_load_en), .bnn_nibble(bnn_nibble), .bnn_out(bnn_out),
      .perf_infer(perf_infer), .perf_stall(perf_stall)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   logic [7:0] model_w [NN];
   logic [7:0] load_bytes [NN];
   logic [7:0] smp [16];
   int         sidx;
   logic [3:0] exp_q[$];
   logic [3:0] got_q[$];
   logic [3:0] nib_q[$];
   int         acc_cyc[$];
   int         pop_cyc[$];
   int ld_en_cnt = 0, rst_cnt = 0, done_cnt = 0, bad_rdy = 0, overlap = 0, rst_cyc = 0;

   function automatic logic neuron(logic [7:0] a, logic [7:0] w);
      return $countones(~(a ^ w)) >= 4;
   endfunction

   // Reference: whole network evaluated from the committed weight set.
   function automatic logic [3:0] ref_out(logic [7:0] x);
      logic [7:0] h;
      logic [3:0] r;
      for (int j = 0; j < 8; j++) h[j] = neuron(x, model_w[j]);
      for (int k = 0; k < 4; k++) r[k] = neuron(h, model_w[8 + k]);
      return r;
   endfunction

   // Behavioural datapath: input reg lives in the DUT, then hidden reg, then output reg.
   logic [7:0] dp_w [NN];
   logic [4:0] dp_ptr;
   logic [7:0] dp_l1;
   logic [3:0] dp_out;
   assign bnn_out = dp_out;

   always @(posedge clk) begin
      if (bnn_rst) begin
         for (int i = 0; i < NN; i++) dp_w[i] <= 8'h00;
         dp_ptr <= '0;
         dp_l1  <= '0;
         dp_out <= '0;
      end else begin
         if (bnn_load_en) begin
            if (!dp_ptr[0]) dp_w[dp_ptr[4:1]][3:0] <= bnn_nibble;
            else            dp_w[dp_ptr[4:1]][7:4] <= bnn_nibble;
            dp_ptr <= dp_ptr + 5'd1;
         end
         for (int j = 0; j < 8; j++) dp_l1[j] <= neuron(bnn_in, dp_w[j]);
         for (int k = 0; k < 4; k++) dp_out[k] <= neuron(dp_l1, dp_w[8 + k]);
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // acc_cyc holds the cycle whose closing edge accepts the sample.
   always @(negedge clk) begin
      if (!reset) begin
         if (in_valid && in_ready) begin exp_q.push_back(ref_out(in_data)); acc_cyc.push_back(cyc); end
         if (out_valid && out_ready) begin got_q.push_back(out_data); pop_cyc.push_back(cyc); end
         if (bnn_load_en) begin ld_en_cnt <= ld_en_cnt + 1; nib_q.push_back(bnn_nibble); end
         if (bnn_rst) begin rst_cnt <= rst_cnt + 1; rst_cyc <= cyc; end
         if (load_done) done_cnt <= done_cnt + 1;
         if (load_done && bnn_load_en) overlap <= overlap + 1;
         if (busy && in_ready) bad_rdy <= bad_rdy + 1;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send_until(input int n, input int budget);
      for (int t = 0; t < budget && sidx < n; t++) begin
         in_valid = 1'b1;
         in_data  = smp[sidx];
         @(negedge clk);
         if (in_ready) sidx++;
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic drain(output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 60; t++) begin
         tick();
         if (got_q.size() >= exp_q.size() && !out_valid) begin ok = 1'b1; break; end
      end
   endtask

   // Pulses wl_start with a competing in_valid, feeds n_bytes with random gaps.
   task automatic do_load(input int n_bytes, output bit ok);
      int i = 0;
      ok = 1'b0;
      in_valid = 1'b1; in_data = 8'($urandom); wl_start = 1'b1;
      tick();
      wl_start = 1'b0; in_valid = 1'b0;
      for (int t = 0; t < 400 && i < n_bytes; t++) begin
         wl_valid = ($urandom_range(0, 3) != 0);
         wl_data  = load_bytes[i];
         @(negedge clk);
         if (wl_valid && wl_ready) i++;
         tick();
      end
      wl_valid = 1'b0;
      if (n_bytes < NN) begin
         ok = (i == n_bytes);
      end else begin
         for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (load_done) begin ok = 1'b1; break; end
         end
         tick();
         if (ok) for (int k = 0; k < NN; k++) model_w[k] = load_bytes[k];
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 0; in_data = 0; out_ready = 0; wl_start = 0; wl_valid = 0; wl_data = 0;
      for (int k = 0; k < NN; k++) model_w[k] = 8'h00;
      @(posedge clk);
      @(negedge clk);
      n_assert++; if (in_ready !== 1'b0)    begin n_fail++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
      n_assert++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
      n_assert++; if (bnn_load_en !== 1'b0) begin n_fail++; $display("FAIL rst_load_en got %b want 0", bnn_load_en); end
      n_assert++; if (bnn_rst !== 1'b1)     begin n_fail++; $display("FAIL rst_bnn_rst got %b want 1", bnn_rst); end
      n_assert++; if (out_data !== 4'h0)    begin n_fail++; $display("FAIL rst_out_data got %h want 0", out_data); end
      tick();
      reset = 1'b0;
      @(negedge clk);
      n_assert++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
      n_assert++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL post_rst_busy got %b want 0", busy); end
      n_assert++; if (bnn_rst !== 1'b0)  begin n_fail++; $display("FAIL post_rst_bnn_rst got %b want 0", bnn_rst); end
      tick();
   endtask

   task automatic test_load_ff();
      int ld0, rst0, done0, acc0, badn;
      bit ok;
      for (int k = 0; k < NN; k++) load_bytes[k] = 8'hFF;
      ld0 = ld_en_cnt; rst0 = rst_cnt; done0 = done_cnt; acc0 = acc_cyc.size();
      nib_q.delete();
      do_load(NN, ok);
      tick(); tick();
      n_assert++; if (!ok) begin n_fail++; $display("FAIL ff_load_timeout got no load_done want load_done"); end
      n_assert++; if (rst_cnt - rst0 !== 1)   begin n_fail++; $display("FAIL ff_rst_pulses got %0d want 1", rst_cnt - rst0); end
      n_assert++; if (ld_en_cnt - ld0 !== 24) begin n_fail++; $display("FAIL ff_load_en_cycles got %0d want 24", ld_en_cnt - ld0); end
      n_assert++; if (done_cnt - done0 !== 1) begin n_fail++; $display("FAIL ff_load_done got %0d want 1", done_cnt - done0); end
      n_assert++; if (acc_cyc.size() - acc0 !== 0) begin n_fail++; $display("FAIL ff_wl_start_priority got %0d accepts want 0", acc_cyc.size() - acc0); end
      badn = 0;
      foreach (nib_q[i]) if (nib_q[i] !== 4'hF) badn++;
      n_assert++; if (badn !== 0 || nib_q.size() !== 24) begin n_fail++; $display("FAIL ff_nibbles got %0d bad of %0d want 0 of 24", badn, nib_q.size()); end
      n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ff_busy_after got %b want 0", busy); end
      n_assert++; if (overlap !== 0) begin n_fail++; $display("FAIL ff_done_overlap got %0d want 0", overlap); end
      exp_q.delete(); got_q.delete();
      out_ready = 1'b1; smp[0] = 8'hFF; smp[1] = 8'h00; sidx = 0;
      send_until(2, 10);
      drain(ok);
      n_assert++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL ff_result_count got %0d want 2", got_q.size()); end
      else begin
         n_assert++; if (got_q[0] !== 4'hF) begin n_fail++; $display("FAIL ff_out_ff got %h want f", got_q[0]); end
         n_assert++; if (got_q[1] !== 4'h0) begin n_fail++; $display("FAIL ff_out_00 got %h want 0", got_q[1]); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_back_to_back();
      bit ok;
      logic [3:0] g;
      acc_cyc.delete(); pop_cyc.delete(); exp_q.delete(); got_q.delete();
      out_ready = 1'b1; sidx = 0;
      for (int i = 0; i < 4; i++) smp[i] = 8'($urandom);
      send_until(4, 4);
      n_assert++; if (sidx !== 4) begin n_fail++; $display("FAIL b2b_accepts got %0d want 4", sidx); end
      drain(ok);
      n_assert++; if (!ok || pop_cyc.size() !== 4) begin n_fail++; $display("FAIL b2b_drain got %0d results want 4", pop_cyc.size()); end
      else begin
         n_assert++; if (acc_cyc[3] - acc_cyc[0] !== 3) begin n_fail++; $display("FAIL b2b_accept_span got %0d want 3", acc_cyc[3] - acc_cyc[0]); end
         n_assert++; if (pop_cyc[0] - acc_cyc[0] - 1 !== 3) begin n_fail++; $display("FAIL b2b_latency got %0d want 3", pop_cyc[0] - acc_cyc[0] - 1); end
         n_assert++; if (pop_cyc[3] - pop_cyc[0] !== 3) begin n_fail++; $display("FAIL b2b_pop_span got %0d want 3", pop_cyc[3] - pop_cyc[0]); end
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         g = (i < got_q.size()) ? got_q[i] : 4'hx;
         n_assert++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL b2b_result[%0d] got %h want %h", i, g, exp_q[i]); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_reload_inflight();
      bit ok;
      int bad0;
      logic [3:0] g;
      acc_cyc.delete(); exp_q.delete(); got_q.delete();
      out_ready = 1'b1; sidx = 0;
      for (int i = 0; i < 5; i++) smp[i] = 8'($urandom);
      for (int k = 0; k < NN; k++) load_bytes[k] = 8'($urandom);
      bad0 = bad_rdy;
      send_until(2, 2);
      do_load(NN, ok);
      n_assert++; if (!ok) begin n_fail++; $display("FAIL rl_load_timeout got no load_done want load_done"); end
      n_assert++; if (acc_cyc.size() !== 2) begin n_fail++; $display("FAIL rl_accepts got %0d want 2", acc_cyc.size()); end
      else begin
         n_assert++; if (rst_cyc < acc_cyc[1] + 4) begin n_fail++; $display("FAIL rl_rst_early got cycle %0d want >= %0d", rst_cyc, acc_cyc[1] + 4); end
      end
      n_assert++; if (bad_rdy !== bad0) begin n_fail++; $display("FAIL rl_in_ready_busy got %0d cycles want 0", bad_rdy - bad0); end
      send_until(5, 20);
      drain(ok);
      n_assert++; if (got_q.size() !== 5) begin n_fail++; $display("FAIL rl_result_count got %0d want 5", got_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         g = (i < got_q.size()) ? got_q[i] : 4'hx;
         n_assert++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL rl_result[%0d] got %h want %h", i, g, exp_q[i]); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [3:0] g;
      exp_q.delete(); got_q.delete();
      out_ready = 1'b0; sidx = 0;
      for (int i = 0; i < 6; i++) smp[i] = 8'($urandom);
      send_until(6, 10);
      @(negedge clk);
      n_assert++; if (sidx !== 4)        begin n_fail++; $display("FAIL bp_accepted got %0d want 4", sidx); end
      n_assert++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
      n_assert++; if (out_data !== exp_q[0]) begin n_fail++; $display("FAIL bp_head got %h want %h", out_data, exp_q[0]); end
      tick(); tick(); tick();
      @(negedge clk);
      n_assert++; if (out_data !== exp_q[0]) begin n_fail++; $display("FAIL bp_head_stable got %h want %h", out_data, exp_q[0]); end
      tick();
      out_ready = 1'b1;
      send_until(6, 20);
      n_assert++; if (sidx !== 6) begin n_fail++; $display("FAIL bp_remaining got %0d want 6", sidx); end
      drain(ok);
      n_assert++; if (got_q.size() !== 6) begin n_fail++; $display("FAIL bp_result_count got %0d want 6", got_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         g = (i < got_q.size()) ? got_q[i] : 4'hx;
         n_assert++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL bp_result[%0d] got %h want %h", i, g, exp_q[i]); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_reset_midload();
      bit ok;
      int ld0, done0;
      logic [3:0] g;
      for (int k = 0; k < NN; k++) load_bytes[k] = 8'($urandom);
      do_load(5, ok);
      n_assert++; if (!ok) begin n_fail++; $display("FAIL mid_partial_feed got timeout want 5 bytes"); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int k = 0; k < NN; k++) model_w[k] = 8'h00;
      @(negedge clk);
      n_assert++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL mid_busy got %b want 0", busy); end
      n_assert++; if (wl_ready !== 1'b0)    begin n_fail++; $display("FAIL mid_wl_ready got %b want 0", wl_ready); end
      n_assert++; if (bnn_load_en !== 1'b0) begin n_fail++; $display("FAIL mid_load_en got %b want 0", bnn_load_en); end
      tick();
      exp_q.delete(); got_q.delete();
      out_ready = 1'b1; sidx = 0;
      for (int i = 0; i < 6; i++) smp[i] = 8'($urandom);
      send_until(2, 10);
      for (int k = 0; k < NN; k++) load_bytes[k] = 8'($urandom);
      ld0 = ld_en_cnt; done0 = done_cnt;
      nib_q.delete();
      do_load(NN, ok);
      tick();
      n_assert++; if (!ok) begin n_fail++; $display("FAIL mid_reload_timeout got no load_done want load_done"); end
      n_assert++; if (ld_en_cnt - ld0 !== 24) begin n_fail++; $display("FAIL mid_load_en_cycles got %0d want 24", ld_en_cnt - ld0); end
      n_assert++; if (done_cnt - done0 !== 1) begin n_fail++; $display("FAIL mid_load_done got %0d want 1", done_cnt - done0); end
      for (int i = 0; i < nib_q.size() && i < 24; i++) begin
         g = (i % 2 == 0) ? load_bytes[i / 2][3:0] : load_bytes[i / 2][7:4];
         n_assert++; if (nib_q[i] !== g) begin n_fail++; $display("FAIL mid_nibble[%0d] got %h want %h", i, nib_q[i], g); end
      end
      send_until(6, 20);
      drain(ok);
      n_assert++; if (got_q.size() !== 6) begin n_fail++; $display("FAIL mid_result_count got %0d want 6", got_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         g = (i < got_q.size()) ? got_q[i] : 4'hx;
         n_assert++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL mid_result[%0d] got %h want %h", i, g, exp_q[i]); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   initial begin
      test_reset();
      test_load_ff();
      test_back_to_back();
      test_reload_inflight();
      test_backpressure();
      test_reset_midload();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end
endmodule
